// File: rtl/dataset_pkg.sv
// Constants and state type shared by the dataset loader and result store control units.
package dataset_pkg;

   localparam int unsigned DATASET_SIZE = 150;
   localparam int unsigned DS_ADDR_W    = 8;
   localparam int unsigned DS_DATA_W    = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      WRITE  = 2'd2,
      DONE   = 2'd3
   } store_state_t;

   // True when a run of n entries starting at base fits an addr_w-bit address space.
   function automatic bit store_range_ok(input int unsigned n, input int unsigned base,
                                         input int unsigned addr_w);
      return (n + base) <= (64'd1 << addr_w);
   endfunction

endpackage

// File: rtl/result_store_cu_if.sv
// Result stream (valid/ready) and result memory write port of the result store control unit.
interface result_store_cu_if #(
   parameter int unsigned ADDR_W = dataset_pkg::DS_ADDR_W,
   parameter int unsigned DATA_W = dataset_pkg::DS_DATA_W
);

   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic [DATA_W-1:0] exp_data;
   logic              in_ready;
   logic              wr_req;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;

   // master: the control unit (consumes results, issues memory writes)
   modport master (
      input  in_valid, in_data, exp_data, wr_ack,
      output in_ready, wr_req, wr_addr, wr_data
   );

   // slave: result producer and memory
   modport slave (
      output in_valid, in_data, exp_data, wr_ack,
      input  in_ready, wr_req, wr_addr, wr_data
   );

endinterface

// File: rtl/store_addr_cnt.sv
// Entry counter for the result store; flags the last entry of a run.
module store_addr_cnt #(
   parameter int unsigned N_ENTRIES = dataset_pkg::DATASET_SIZE,
   parameter int unsigned ADDR_W    = dataset_pkg::DS_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   output logic [ADDR_W-1:0] cnt,
   output logic              last
);

   logic [ADDR_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == ADDR_W'(N_ENTRIES - 1));

endmodule

// File: rtl/result_store_cu.sv
// Result store control unit: writes N_ENTRIES handshaked results to sequential memory addresses.
// Define RESULT_STORE_ERRCNT_EN to build the result/label mismatch counter.
module result_store_cu
   import dataset_pkg::*;
#(
   parameter int unsigned N_ENTRIES = DATASET_SIZE,
   parameter int unsigned ADDR_W    = DS_ADDR_W,
   parameter int unsigned DATA_W    = DS_DATA_W,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   result_store_cu_if.master    bus,
   output logic                 busy,
   output logic                 done,
   output logic [ADDR_W-1:0]    err_cnt
);

   store_state_t      state_q, state_d;
   logic [DATA_W-1:0] data_q;
   logic [ADDR_W-1:0] cnt;
   logic              cnt_last;
   logic              run_start;
   logic              capture;
   logic              wr_done;

   assign run_start = (state_q == IDLE) && start;
   assign capture   = (state_q == ACCEPT) && bus.in_valid;
   assign wr_done   = (state_q == WRITE) && bus.wr_ack;

   store_addr_cnt #(
      .N_ENTRIES (N_ENTRIES),
      .ADDR_W    (ADDR_W)
   ) u_addr_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (run_start),
      .inc  (wr_done && !cnt_last),
      .cnt  (cnt),
      .last (cnt_last)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            data_q <= bus.in_data;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      bus.in_ready = 1'b0;
      bus.wr_req   = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCEPT;
            end
         end
         ACCEPT: begin
            bus.in_ready = 1'b1;
            busy         = 1'b1;
            if (bus.in_valid) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            bus.wr_req = 1'b1;
            busy       = 1'b1;
            if (bus.wr_ack) begin
               state_d = cnt_last ? DONE : ACCEPT;
            end
         end
         DONE: begin
            done    = 1'b1;
            busy    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Address and data come straight from registers so they hold steady during an ack stall.
   assign bus.wr_addr = ADDR_W'(BASE_ADDR) + cnt;
   assign bus.wr_data = data_q;

`ifdef RESULT_STORE_ERRCNT_EN
   logic [DATA_W-1:0] exp_q;
   logic [ADDR_W-1:0] err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q <= '0;
         err_q <= '0;
      end else begin
         if (capture) begin
            exp_q <= bus.exp_data;
         end
         if (run_start) begin
            err_q <= '0;
         end else if (wr_done && (data_q != exp_q) && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
         end
      end
   end

   assign err_cnt = err_q;
`else
   // Port kept so both builds share one interface.
   logic unused_exp_data;
   assign unused_exp_data = ^bus.exp_data;
   assign err_cnt         = '0;
`endif

endmodule

// File: tb/tb_result_store_cu.sv
// Randomized bench for result_store_cu against a queue-based model of the stored result sequence.
module tb_result_store_cu;
   import dataset_pkg::*;

   localparam int unsigned N    = DATASET_SIZE;
   localparam int unsigned AW   = DS_ADDR_W;
   localparam int unsigned DW   = DS_DATA_W;
   localparam int unsigned BASE = 0;
   localparam int          BUDGET = 5000;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          done;
   logic [AW-1:0] err_cnt;

   int n_cmp = 0;
   int n_mis = 0;

   result_store_cu_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   result_store_cu #(
      .N_ENTRIES (N),
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .BASE_ADDR (BASE)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string pfx);
      check_eq({pfx, "_in_ready"}, bus.in_ready, 0);
      check_eq({pfx, "_wr_req"},   bus.wr_req, 0);
      check_eq({pfx, "_wr_addr"},  bus.wr_addr, BASE);
      check_eq({pfx, "_wr_data"},  bus.wr_data, 0);
      check_eq({pfx, "_busy"},     busy, 0);
      check_eq({pfx, "_done"},     done, 0);
      check_eq({pfx, "_err_cnt"},  err_cnt, 0);
   endtask

   // One run. Cycle t = edge index counted from the start-sampling edge (edge 0); values seen
   // at a negedge are the ones the following edge samples.
   task automatic do_run(input int valid_pct, input int ack_pct, input int n_bad,
                         input int stall_idx, input int gap_idx, input int abort_at,
                         input bit chk_timing);
      bit            bad [N];
      logic [DW-1:0] acc_q [$];
      int            writes = 0, accepted = 0, cyc = 0, stall_cnt = 0, gap_cnt = 0;
      int            overlap = 0, exp_err = 0, nb = 0, t;
      bit            done_seen = 0, prev_pend = 0, vld, ack;
      logic [AW-1:0] prev_addr = '0;
      logic [DW-1:0] prev_data = '0, d;

      for (int i = 0; i < N; i++) bad[i] = 1'b0;
      while (nb < n_bad) begin
         int k = $urandom_range(N - 1);
         if (!bad[k]) begin
            bad[k] = 1'b1;
            nb++;
         end
      end
`ifdef RESULT_STORE_ERRCNT_EN
      exp_err = n_bad;
`endif

      @(negedge clk);
      start        = 1'b1;
      bus.in_valid = 1'b0;
      bus.wr_ack   = 1'b0;
      @(negedge clk);
      start = 1'b0;

      while (!done_seen && cyc < BUDGET && cyc != abort_at) begin
         t = cyc + 1;
         if (bus.in_ready && bus.wr_req) overlap++;

         // Producer: random data, label corrupted for the chosen entries.
         d   = DW'($urandom);
         vld = ($urandom_range(99) < valid_pct);
         if (accepted == gap_idx && bus.in_ready && gap_cnt < 10) begin
            vld = 1'b0;
            gap_cnt++;
            check_eq("gap_addr", bus.wr_addr, BASE + accepted);
         end
         bus.in_valid = vld;
         bus.in_data  = d;
         bus.exp_data = (accepted < N && bad[accepted]) ? (d ^ DW'(1)) : d;
         if (bus.in_ready && vld) begin
            acc_q.push_back(d);
            accepted++;
         end

         // Memory: random acknowledge, fixed 4-cycle write on the stall entry.
         if (bus.wr_req) begin
            if (prev_pend) begin
               check_eq("hold_addr", bus.wr_addr, prev_addr);
               check_eq("hold_data", bus.wr_data, prev_data);
            end
            if (writes == stall_idx) begin
               stall_cnt++;
               ack = (stall_cnt == 4);
            end else begin
               ack = ($urandom_range(99) < ack_pct);
            end
            if (ack) begin
               check_eq("wr_order", acc_q.size(), writes + 1);
               check_eq("wr_addr", bus.wr_addr, BASE + writes);
               if (writes < acc_q.size()) check_eq("wr_data", bus.wr_data, acc_q[writes]);
               if (chk_timing) check_eq("wr_cycle", t, 2 * writes + 2);
               writes++;
            end
            prev_pend = !ack;
            prev_addr = bus.wr_addr;
            prev_data = bus.wr_data;
         end else begin
            ack       = 1'($urandom_range(1));
            prev_pend = 1'b0;
         end
         bus.wr_ack = ack;

         start = ($urandom_range(99) < 5);
         if (done) begin
            done_seen = 1'b1;
            start     = 1'b1;
            check_eq("done_writes", writes, N);
            check_eq("done_accepts", accepted, N);
            check_eq("done_busy", busy, 1);
            check_eq("done_err_cnt", err_cnt, exp_err);
            if (chk_timing) check_eq("done_cycle", t, 2 * N + 1);
         end
         @(negedge clk);
         cyc++;
      end

      if (abort_at >= 0 && cyc == abort_at) return;
      check_eq("done_seen", done_seen, 1);
      check_eq("ready_req_overlap", overlap, 0);
      if (chk_timing) check_eq("idle_cycle", cyc + 1, 2 * N + 2);
      check_eq("post_busy", busy, 0);
      check_eq("post_done", done, 0);
      check_eq("post_in_ready", bus.in_ready, 0);
      check_eq("post_err_cnt", err_cnt, exp_err);
      start        = 1'b0;
      bus.in_valid = 1'b1;
      bus.wr_ack   = 1'b1;
      @(negedge clk);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_wr_req", bus.wr_req, 0);
      check_eq("idle_err_hold", err_cnt, exp_err);
      bus.in_valid = 1'b0;
      bus.wr_ack   = 1'b0;
   endtask

   initial begin
      rst          = 1'b0;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.exp_data = '0;
      bus.wr_ack   = 1'b0;
      #12;
      check_reset_outputs("rst");
      @(negedge clk);
      rst = 1'b1;

      do_run(100, 100, 7, -1, -1, -1, 1'b1);

      do_run(70, 60, 0, -1, -1, 40, 1'b0);
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.wr_ack   = 1'b0;
      rst          = 1'b0;
      #1;
      check_reset_outputs("mid_rst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_rst");

      do_run(60, 60, 3, 5, 7, -1, 1'b0);
      do_run(40, 30, 0, -1, -1, -1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
